// File: rtl/shared_pkg.sv
// Shared definitions for the SPI slave / RAM slice: data width, frame
// control codes and the receiver FSM states.
package shared_pkg;

  localparam int MEM_WIDTH = 8;

  typedef enum logic [1:0] {
    WR_ADDR = 2'b00,
    WR_DATA = 2'b01,
    RD_ADDR = 2'b10,
    RD_DATA = 2'b11
  } control_e;

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_e;

endpackage

// File: rtl/spi_slave.sv
// SPI slave front end: deserializes MEM_WIDTH+2 bit command frames for the RAM
// and serializes read data back on MISO once the RAM answers a read-data frame.
module spi_slave
  import shared_pkg::*;
#(
  parameter int MEM_WIDTH = shared_pkg::MEM_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 SS_n,
  input  logic                 MOSI,
  output logic                 MISO,
  output logic [MEM_WIDTH+1:0] rx_data,
  output logic                 rx_valid,
  input  logic [MEM_WIDTH-1:0] tx_data,
  input  logic                 tx_valid
);

  localparam int FRAME_W = MEM_WIDTH + 2;
  localparam int CNT_W   = $clog2(FRAME_W);
  localparam int TXC_W   = $clog2(MEM_WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(FRAME_W - 1);
  localparam logic [TXC_W-1:0] TX_REMAIN = TXC_W'(MEM_WIDTH - 1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic                 frame_done_q, frame_done_d;
  logic [MEM_WIDTH:0]   rx_shift_q, rx_shift_d;
  logic [FRAME_W-1:0]   rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 rd_addr_received_q, rd_addr_received_d;
  logic [MEM_WIDTH-1:0] tx_shift_q, tx_shift_d;
  logic [TXC_W-1:0]     tx_cnt_q, tx_cnt_d;
  logic                 tx_taken_q, tx_taken_d;
  logic                 miso_q, miso_d;

  logic [FRAME_W-1:0]   frame_full;

  assign frame_full = {rx_shift_q, MOSI};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q            <= IDLE;
      bit_cnt_q          <= '0;
      frame_done_q       <= 1'b0;
      rx_shift_q         <= '0;
      rx_data_q          <= '0;
      rx_valid_q         <= 1'b0;
      rd_addr_received_q <= 1'b0;
      tx_shift_q         <= '0;
      tx_cnt_q           <= '0;
      tx_taken_q         <= 1'b0;
      miso_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      bit_cnt_q          <= bit_cnt_d;
      frame_done_q       <= frame_done_d;
      rx_shift_q         <= rx_shift_d;
      rx_data_q          <= rx_data_d;
      rx_valid_q         <= rx_valid_d;
      rd_addr_received_q <= rd_addr_received_d;
      tx_shift_q         <= tx_shift_d;
      tx_cnt_q           <= tx_cnt_d;
      tx_taken_q         <= tx_taken_d;
      miso_q             <= miso_d;
    end
  end

  // A 1 command bit means read-data only when an address frame came first.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!SS_n) state_d = CHK_CMD;
      end
      CHK_CMD: begin
        if (SS_n)                    state_d = IDLE;
        else if (!MOSI)              state_d = WRITE;
        else if (rd_addr_received_q) state_d = READ_DATA;
        else                         state_d = READ_ADD;
      end
      WRITE, READ_ADD, READ_DATA: begin
        if (SS_n) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Receive path; frame_done_q blocks further shifting until SS_n rises.
  always_comb begin
    bit_cnt_d          = bit_cnt_q;
    frame_done_d       = frame_done_q;
    rx_shift_d         = rx_shift_q;
    rx_data_d          = rx_data_q;
    rx_valid_d         = 1'b0;
    rd_addr_received_d = rd_addr_received_q;
    if (state_q == IDLE || SS_n) begin
      bit_cnt_d    = '0;
      frame_done_d = 1'b0;
      rx_shift_d   = '0;
    end else if (state_q == CHK_CMD) begin
      rx_shift_d = {{MEM_WIDTH{1'b0}}, MOSI};
      bit_cnt_d  = CNT_W'(1);
    end else if (!frame_done_q) begin
      if (bit_cnt_q == LAST_BIT) begin
        rx_data_d    = frame_full;
        rx_valid_d   = 1'b1;
        frame_done_d = 1'b1;
        bit_cnt_d    = '0;
        rx_shift_d   = '0;
        if (state_q == READ_ADD)       rd_addr_received_d = 1'b1;
        else if (state_q == READ_DATA) rd_addr_received_d = 1'b0;
      end else begin
        rx_shift_d = {rx_shift_q[MEM_WIDTH-1:0], MOSI};
        bit_cnt_d  = bit_cnt_q + CNT_W'(1);
      end
    end
  end

  // Transmit path: one tx_data capture per read-data frame, then MSB first.
  always_comb begin
    tx_shift_d = tx_shift_q;
    tx_cnt_d   = tx_cnt_q;
    tx_taken_d = tx_taken_q;
    miso_d     = 1'b0;
    if (state_q != READ_DATA || SS_n) begin
      tx_shift_d = '0;
      tx_cnt_d   = '0;
      tx_taken_d = 1'b0;
    end else if (tx_cnt_q != '0) begin
      miso_d     = tx_shift_q[MEM_WIDTH-1];
      tx_shift_d = tx_shift_q << 1;
      tx_cnt_d   = tx_cnt_q - TXC_W'(1);
    end else if (frame_done_q && !tx_taken_q && tx_valid) begin
      miso_d     = tx_data[MEM_WIDTH-1];
      tx_shift_d = tx_data << 1;
      tx_cnt_d   = TX_REMAIN;
      tx_taken_d = 1'b1;
    end
  end

  assign MISO     = miso_q;
  assign rx_data  = rx_data_q;
  assign rx_valid = rx_valid_q;

endmodule

// File: doc/spi_slave.md
SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter MEM_WIDTH, default 8, data/address width; frame width SHALL be MEM_WIDTH+2.
REQ-002 clk  input  1  clock; all logic on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 SS_n  input  1  slave select, active-low; high = no frame.
REQ-005 MOSI  input  1  serial data from master, MSB first.
REQ-006 MISO  output  1  serial read data to master, MSB first.
REQ-007 rx_data  output  MEM_WIDTH+2  deserialized frame: [MEM_WIDTH+1:MEM_WIDTH] control (control_e), [MEM_WIDTH-1:0] payload.
REQ-008 rx_valid  output  1  one-cycle strobe, rx_data valid.
REQ-009 tx_data  input  MEM_WIDTH  read data returned by RAM.
REQ-010 tx_valid  input  1  one-cycle strobe, tx_data valid.

Function
REQ-011 FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
REQ-012 IDLE -> CHK_CMD when SS_n=0; otherwise stay.
REQ-013 CHK_CMD samples MOSI as rx bit MEM_WIDTH+1: 0 -> WRITE; 1 with rd_addr_received=0 -> READ_ADD; 1 with rd_addr_received=1 -> READ_DATA.
REQ-014 WRITE/READ_ADD/READ_DATA shift in the remaining MEM_WIDTH+1 bits, one per clk, MSB first; bit counter 0..MEM_WIDTH+1.
REQ-015 Cycle after the last (10th for default) bit: rx_data holds full frame, rx_valid=1 for exactly one cycle.
REQ-016 rx_data SHALL hold its value until the next frame completes; partial shifting uses an internal register.
REQ-017 After rx_valid, further MOSI bits ignored until SS_n=1.
REQ-018 rd_addr_received: set on rx_valid in READ_ADD; cleared on rx_valid in READ_DATA; unchanged otherwise.
REQ-019 READ_DATA after rx_valid: wait for tx_valid; on tx_valid=1 capture tx_data; MISO drives bits MEM_WIDTH-1..0 on the following MEM_WIDTH cycles (registered).
REQ-020 tx_valid outside that wait window SHALL be ignored.
REQ-021 MISO=0 whenever not serializing.
REQ-022 SS_n=1 in any non-IDLE state -> IDLE next cycle; abort: bit counter cleared, no rx_valid, serialization stopped, MISO=0, rd_addr_received unchanged.
REQ-023 SS_n=1 on the cycle the last bit would be sampled: frame aborted, no rx_valid.
REQ-024 Frames with SS_n held low after completion: no new frame until SS_n returns high then low.

Reset
REQ-025 rst_n=0 at a clk edge: state=IDLE, rx_data=0, rx_valid=0, MISO=0, counters=0, rd_addr_received=0, shift registers=0.
REQ-026 Reset mid-frame or mid-serialization SHALL discard all progress; no strobe issued.

Structure
REQ-027 shared_pkg SHALL hold MEM_WIDTH, control_e (WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11) and the FSM state enum.
REQ-028 Single module, no sub-module; one state register, one bit counter, rx shift register, tx shift register.
REQ-029 rx_data/rx_valid/tx_data/tx_valid SHALL connect directly to the RAM stage without glue.

Verification
REQ-030 SS_n low, MOSI 0,0,0x25 (10 bits 00_00100101) -> one cycle after 10th bit rx_data=0x025, rx_valid=1 once.
REQ-031 Write frame 01_0xA5 -> rx_data=0x1A5, rx_valid pulse; state WRITE until SS_n high.
REQ-032 Read-address frame 10_0x25 then read-data frame 11_0x00; RAM returns tx_valid with tx_data=0xA5 -> MISO 1,0,1,0,0,1,0,1 on next 8 cycles; rd_addr_received 0->1->0.
REQ-033 SS_n raised after 5 bits of write frame -> no rx_valid, IDLE next cycle, rx_data unchanged.
REQ-034 Second 1-prefixed frame without prior read-address (rd_addr_received=0) -> routed to READ_ADD; tx_valid pulse during READ_ADD -> MISO stays 0.
REQ-035 rst_n=0 during MISO serialization of 0xFF -> MISO=0, state IDLE, rd_addr_received=0 next cycle.
